// File: rtl/uart_ram_loader.sv
// UART boot loader: receives a length byte N and N image bytes over 8N1,
// writes them to RAM addresses 0..N-1, then raises cpu_run.
// Ports: clk, rst_n (async, active low), uart_rx (async serial in);
//        ram_wadr/ram_wdata/ram_wen (write bus), cpu_run, load_busy, frame_err.
module uart_ram_loader #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] ram_wadr,
    output logic [7:0] ram_wdata,
    output logic       ram_wen,
    output logic       cpu_run,
    output logic       load_busy,
    output logic       frame_err
);

    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic [1:0] {L_LEN, L_DATA, L_RUN} ld_state_e;

    logic        rx_s1_q, rx_s2_q;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        rx_valid, rx_ferr;

    ld_state_e   ld_state_q, ld_state_d;
    logic [7:0]  addr_q, addr_d;
    logic [8:0]  rem_q, rem_d;
    logic [7:0]  wadr_q, wadr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wen_q, wen_d;
    logic        run_q, run_d;
    logic        busy_q, busy_d;
    logic        ferr_q, ferr_d;

    // Two-flop synchroniser, preset to the idle line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= uart_rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= R_IDLE;
            timer_q    <= '0;
            bitcnt_q   <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            timer_q    <= timer_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        timer_d    = timer_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        rx_valid   = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                timer_d  = '0;
                bitcnt_d = '0;
                if (!rx_s2_q) rx_state_d = R_START;
            end
            R_START: begin
                if (timer_q == HALF) begin
                    timer_d    = '0;
                    // A line already back high is a glitch, not a start bit
                    rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            R_DATA: begin
                if (timer_q == FULL) begin
                    timer_d  = '0;
                    shift_d  = {rx_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) rx_state_d = R_STOP;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            R_STOP: begin
                if (timer_q == FULL) begin
                    timer_d    = '0;
                    rx_state_d = R_IDLE;
                    rx_valid   = rx_s2_q;
                    rx_ferr    = !rx_s2_q;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state_q <= L_LEN;
            addr_q     <= '0;
            rem_q      <= '0;
            wadr_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            wadr_q     <= wadr_d;
            wdata_q    <= wdata_d;
            wen_q      <= wen_d;
            run_q      <= run_d;
            busy_q     <= busy_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        ld_state_d = ld_state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        wadr_d     = wadr_q;
        wdata_d    = wdata_q;
        wen_d      = 1'b0;
        run_d      = run_q;
        busy_d     = busy_q;
        ferr_d     = ferr_q;
        if (rx_ferr) begin
            ferr_d     = 1'b1;
            run_d      = 1'b0;
            busy_d     = 1'b0;
            ld_state_d = L_LEN;
        end else if (rx_valid) begin
            case (ld_state_q)
                L_LEN, L_RUN: begin
                    // Length 0 encodes a full 256-byte image
                    rem_d      = (shift_q == 8'd0) ? 9'd256 : {1'b0, shift_q};
                    addr_d     = '0;
                    busy_d     = 1'b1;
                    run_d      = 1'b0;
                    ld_state_d = L_DATA;
                end
                L_DATA: begin
                    wen_d   = 1'b1;
                    wadr_d  = addr_q;
                    wdata_d = shift_q;
                    addr_d  = addr_q + 8'd1;
                    rem_d   = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        ld_state_d = L_RUN;
                        busy_d     = 1'b0;
                        run_d      = 1'b1;
                        ferr_d     = 1'b0;
                    end
                end
                default: ld_state_d = L_LEN;
            endcase
        end
    end

    assign ram_wadr  = wadr_q;
    assign ram_wdata = wdata_q;
    assign ram_wen   = wen_q;
    assign cpu_run   = run_q;
    assign load_busy = busy_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader at CLKS_PER_BIT=16.
// A monitor logs every RAM write; tests compare the log with hand-derived values.
module tb_uart_ram_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic [7:0] ram_wadr;
    logic [7:0] ram_wdata;
    logic       ram_wen;
    logic       cpu_run;
    logic       load_busy;
    logic       frame_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_stop_cyc = 0;
    int consec = 0;
    logic prev_wen = 1'b0;

    logic [7:0] wa[$];
    logic [7:0] wd[$];
    logic       wrun[$];
    logic       wbusy[$];
    int         wdel[$];

    uart_ram_loader #(.CLKS_PER_BIT(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart_rx(uart_rx),
        .ram_wadr(ram_wadr),
        .ram_wdata(ram_wdata),
        .ram_wen(ram_wen),
        .cpu_run(cpu_run),
        .load_busy(load_busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_wen) begin
            wa.push_back(ram_wadr);
            wd.push_back(ram_wdata);
            wrun.push_back(cpu_run);
            wbusy.push_back(load_busy);
            wdel.push_back(cyc - last_stop_cyc);
            if (prev_wen) consec = consec + 1;
        end
        prev_wen = ram_wen;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wrun.delete();
        wbusy.delete();
        wdel.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) @(negedge clk);
        end
        uart_rx = stop;
        last_stop_cyc = cyc;
        repeat (16) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int bad;
        uart_rx = 1'b1;
        rst_n   = 1'b0;

        // 1. reset
        idle(5);
        check("reset_outs",
              {16'd0, ram_wadr, ram_wdata, ram_wen, cpu_run, load_busy, frame_err},
              32'd0);
        rst_n = 1'b1;
        idle(1000);
        check("reset_no_wr", wa.size(), 0);

        // 2. small load
        send_byte(8'h03, 1'b1);
        idle(2);
        check("len_busy", {load_busy, cpu_run}, 2'b10);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        idle(4);
        check("ld_count", wa.size(), 3);
        if (wa.size() == 3) begin
            check("ld_w0", {wa[0], wd[0]}, 16'h00AA);
            check("ld_w1", {wa[1], wd[1]}, 16'h01BB);
            check("ld_w2", {wa[2], wd[2]}, 16'h02CC);
            check("ld_runbusy", {wrun[0], wbusy[0], wrun[1], wbusy[1], wrun[2], wbusy[2]},
                  6'b01_01_10);
            for (int i = 0; i < 3; i++)
                check("ld_latency", (wdel[i] >= 9 && wdel[i] <= 13), 1);
        end
        check("ld_final", {cpu_run, load_busy, frame_err}, 3'b100);

        // 3. full 256-byte image
        clear_log();
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b1);
        idle(4);
        check("full_count", wa.size(), 256);
        bad = 0;
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] !== 8'(i) || wd[i] !== 8'(i)) bad++;
        check("full_data", bad, 0);
        if (wa.size() == 256) begin
            check("full_last", {wa[255], wd[255], wrun[255]}, {8'hFF, 8'hFF, 1'b1});
            check("full_mid_run", wrun[254], 0);
        end
        check("full_final", {cpu_run, load_busy}, 2'b10);

        // 4. framing error
        clear_log();
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h33, 1'b0);
        idle(40);
        check("ferr_flags", {frame_err, cpu_run, load_busy}, 3'b100);
        check("ferr_count", wa.size(), 1);
        if (wa.size() >= 1) check("ferr_w0", {wa[0], wd[0]}, 16'h0011);
        clear_log();
        send_byte(8'h01, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(4);
        check("ferr_recover_n", wa.size(), 1);
        if (wa.size() >= 1) check("ferr_recover_w", {wa[0], wd[0]}, 16'h0022);
        check("ferr_clear", {cpu_run, frame_err}, 2'b10);

        // 5. glitch
        clear_log();
        @(negedge clk);
        uart_rx = 1'b0;
        idle(4);
        uart_rx = 1'b1;
        idle(300);
        check("glitch_wr", wa.size(), 0);
        check("glitch_flags", {cpu_run, load_busy, frame_err}, 3'b100);

        // 6. reload then reset mid byte
        send_byte(8'h01, 1'b1);
        idle(2);
        check("reload_len", {cpu_run, load_busy}, 2'b01);
        send_byte(8'h5A, 1'b1);
        idle(4);
        check("reload_n", wa.size(), 1);
        if (wa.size() >= 1) check("reload_w", {wa[0], wd[0]}, 16'h005A);
        check("reload_run", cpu_run, 1);
        send_byte(8'h02, 1'b1);
        @(negedge clk);
        uart_rx = 1'b0;
        idle(16);
        uart_rx = 1'b1;
        idle(8);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst",
              {ram_wadr, ram_wdata, ram_wen, cpu_run, load_busy, frame_err}, 12'd0);
        idle(3);
        uart_rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        clear_log();
        idle(200);
        check("post_rst_no_wr", wa.size(), 0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h77, 1'b1);
        idle(4);
        check("post_rst_n", wa.size(), 1);
        if (wa.size() >= 1) check("post_rst_w", {wa[0], wd[0]}, 16'h0077);
        check("post_rst_run", {cpu_run, frame_err}, 2'b10);

        check("no_b2b_wen", consec, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
